count_seq_monitor: RTL and testbench

- Downstream consumer of the 4-bit free-running up-counter; samples its `out` bus every clock.
- Checks that the sequence is legal and counts wrap-arounds (max to 0).
- Flags compare matches and raises a level interrupt with an acknowledge handshake.
- Sits between the counter and the status/interrupt logic.

---
 rtl/count_seq_monitor.sv | 160 ++++++++++++++++
 tb/tb_count_seq_monitor.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_monitor.sv
// Sequence monitor for a free-running up-counter: checks legal steps, counts wraps,
// flags compare matches and raises a level interrupt with acknowledge.
module count_seq_monitor #(
    parameter int CNT_W  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [CNT_W-1:0]  count_in,
    input  logic [CNT_W-1:0]  match_val,
    input  logic              match_en,
    input  logic              err_clr,
    input  logic              irq_ack,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              wrap_pulse,
    output logic              match_pulse,
    output logic              restart_seen,
    output logic              seq_err,
    output logic              irq
);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN,
        ERR
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   prev_q, prev_d;
    logic [WRAP_W-1:0]  wrap_cnt_q, wrap_cnt_d;
    logic               wrap_pulse_q, wrap_pulse_d;
    logic               match_pulse_q, match_pulse_d;
    logic               restart_seen_q, restart_seen_d;
    logic               seq_err_q, seq_err_d;
    logic               irq_q, irq_d;

    logic               prev_is_max;
    logic               is_hold;
    logic               is_step;
    logic               is_wrap;
    logic               is_restart;
    logic               val_match;
    logic               enter_err;

    // A zero after a non-zero, non-max value means the upstream counter was reset.
    assign prev_is_max = (prev_q == CNT_MAX);
    assign is_hold     = (count_in == prev_q);
    assign is_step     = !prev_is_max && (count_in == prev_q + CNT_W'(1));
    assign is_wrap     = prev_is_max && (count_in == '0);
    assign is_restart  = (count_in == '0) && (prev_q != '0) && !prev_is_max;
    assign val_match   = match_en && (count_in == match_val);

    always_comb begin
        state_d        = state_q;
        prev_d         = prev_q;
        wrap_cnt_d     = wrap_cnt_q;
        wrap_pulse_d   = 1'b0;
        match_pulse_d  = 1'b0;
        restart_seen_d = restart_seen_q;
        enter_err      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d        = PRIME;
                    wrap_cnt_d     = '0;
                    restart_seen_d = 1'b0;
                end
            end

            PRIME: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    prev_d  = count_in;
                    state_d = RUN;
                end
            end

            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (is_hold) begin
                    prev_d = count_in;
                end else if (is_step || is_wrap || is_restart) begin
                    prev_d        = count_in;
                    match_pulse_d = val_match;
                    if (is_wrap) begin
                        wrap_pulse_d = 1'b1;
                        if (wrap_cnt_q != WRAP_MAX) begin
                            wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
                        end
                    end
                    if (is_restart) begin
                        restart_seen_d = 1'b1;
                    end
                end else begin
                    state_d   = ERR;
                    enter_err = 1'b1;
                end
            end

            ERR: begin
                if (err_clr) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        seq_err_d = (state_d == ERR);

        // A set event on the same edge as an acknowledge wins.
        if (match_pulse_d || enter_err) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            prev_q         <= '0;
            wrap_cnt_q     <= '0;
            wrap_pulse_q   <= 1'b0;
            match_pulse_q  <= 1'b0;
            restart_seen_q <= 1'b0;
            seq_err_q      <= 1'b0;
            irq_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_q         <= prev_d;
            wrap_cnt_q     <= wrap_cnt_d;
            wrap_pulse_q   <= wrap_pulse_d;
            match_pulse_q  <= match_pulse_d;
            restart_seen_q <= restart_seen_d;
            seq_err_q      <= seq_err_d;
            irq_q          <= irq_d;
        end
    end

    assign wrap_cnt     = wrap_cnt_q;
    assign wrap_pulse   = wrap_pulse_q;
    assign match_pulse  = match_pulse_q;
    assign restart_seen = restart_seen_q;
    assign seq_err      = seq_err_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Self-checking bench for count_seq_monitor: a reference model feeds a scoreboard queue,
// and hand-derived vector tables cover the match, error, restart and reset sequences.
module tb_count_seq_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] count_in;
    logic [3:0] match_val;
    logic       match_en;
    logic       err_clr;
    logic       irq_ack;

    logic [7:0] wrap_cnt;
    logic       wrap_pulse, match_pulse, restart_seen, seq_err, irq;
    logic [1:0] wrap_cnt2;
    logic       wrap_pulse2, match_pulse2, restart_seen2, seq_err2, irq2;

    always #5 clk = ~clk;

    count_seq_monitor #(.CNT_W(4), .WRAP_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .count_in(count_in),
        .match_val(match_val), .match_en(match_en), .err_clr(err_clr), .irq_ack(irq_ack),
        .wrap_cnt(wrap_cnt), .wrap_pulse(wrap_pulse), .match_pulse(match_pulse),
        .restart_seen(restart_seen), .seq_err(seq_err), .irq(irq)
    );

    // Narrow accumulator copy, used to see saturation at 3.
    count_seq_monitor #(.CNT_W(4), .WRAP_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .count_in(count_in),
        .match_val(match_val), .match_en(match_en), .err_clr(err_clr), .irq_ack(irq_ack),
        .wrap_cnt(wrap_cnt2), .wrap_pulse(wrap_pulse2), .match_pulse(match_pulse2),
        .restart_seen(restart_seen2), .seq_err(seq_err2), .irq(irq2)
    );

    typedef struct packed {
        logic [7:0] wc8;
        logic [1:0] wc2;
        logic       wp;
        logic       mp;
        logic       rs;
        logic       se;
        logic       irq;
    } out_t;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic [3:0] ci;
        logic [3:0] mv;
        logic       me;
        logic       ec;
        logic       ack;
        logic [7:0] wc;
        logic       wp;
        logic       mp;
        logic       rs;
        logic       se;
        logic       irq;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    out_t sbq[$];
    vec_t tab[$];

    int         m_st;
    logic [3:0] m_prev;
    out_t       m_out;

    function automatic vec_t mk(input logic rst, input logic e, input int ci, input int mv,
                                input logic me, input logic ec, input logic ack,
                                input int wc, input logic wp, input logic mp,
                                input logic rs, input logic se, input logic iq);
        vec_t v;
        v.rst = rst; v.en = e; v.ci = 4'(ci); v.mv = 4'(mv);
        v.me = me; v.ec = ec; v.ack = ack;
        v.wc = 8'(wc); v.wp = wp; v.mp = mp; v.rs = rs; v.se = se; v.irq = iq;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: states 0=IDLE 1=PRIME 2=RUN 3=ERR, advanced once per clock edge.
    task automatic modelStep();
        bit cand;
        bit setIrq;
        cand     = 0;
        setIrq   = 0;
        m_out.wp = 1'b0;
        m_out.mp = 1'b0;
        if (!reset) begin
            m_st   = 0;
            m_prev = 4'd0;
            m_out  = '0;
            return;
        end
        case (m_st)
            0: if (en) begin
                m_st = 1; m_out.wc8 = 8'd0; m_out.wc2 = 2'd0; m_out.rs = 1'b0;
            end
            1: if (en) begin
                m_prev = count_in; m_st = 2;
            end else begin
                m_st = 0;
            end
            2: if (!en) begin
                m_st = 0;
            end else if (count_in == m_prev) begin
                m_prev = count_in;
            end else if (m_prev == 4'd15 && count_in == 4'd0) begin
                m_out.wp = 1'b1;
                if (int'(m_out.wc8) < 255) m_out.wc8 = m_out.wc8 + 8'd1;
                if (int'(m_out.wc2) < 3) m_out.wc2 = m_out.wc2 + 2'd1;
                m_prev = count_in; cand = 1;
            end else if (count_in == 4'd0) begin
                m_out.rs = 1'b1; m_prev = count_in; cand = 1;
            end else if (int'(m_prev) + 1 == int'(count_in)) begin
                m_prev = count_in; cand = 1;
            end else begin
                m_st = 3; setIrq = 1;
            end
            default: if (err_clr) m_st = 0;
        endcase
        if (cand && match_en && count_in == match_val) begin
            m_out.mp = 1'b1; setIrq = 1;
        end
        m_out.se = (m_st == 3);
        if (setIrq) m_out.irq = 1'b1;
        else if (irq_ack) m_out.irq = 1'b0;
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [3:0] ci,
                                 input logic [3:0] mv, input logic me, input logic ec,
                                 input logic ack);
        @(negedge clk);
        reset = r; en = e; count_in = ci; match_val = mv;
        match_en = me; err_clr = ec; irq_ack = ack;
        modelStep();
        sbq.push_back(m_out);
        @(posedge clk);
        #1;
    endtask

    task automatic compareTo(input string tag, input out_t exp);
        chk({tag, "wrap_cnt"}, 32'(wrap_cnt), 32'(exp.wc8));
        chk({tag, "wrap_cnt_w2"}, 32'(wrap_cnt2), 32'(exp.wc2));
        chk({tag, "wrap_pulse"}, 32'(wrap_pulse), 32'(exp.wp));
        chk({tag, "wrap_pulse_w2"}, 32'(wrap_pulse2), 32'(exp.wp));
        chk({tag, "match_pulse"}, 32'(match_pulse), 32'(exp.mp));
        chk({tag, "restart_seen"}, 32'(restart_seen), 32'(exp.rs));
        chk({tag, "seq_err"}, 32'(seq_err), 32'(exp.se));
        chk({tag, "irq"}, 32'(irq), 32'(exp.irq));
    endtask

    task automatic checkOutput();
        out_t exp;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            exp = sbq.pop_front();
            compareTo("sb_", exp);
        end
    endtask

    task automatic checkTable(input int i);
        chk($sformatf("tab%0d_wrap_cnt", i), 32'(wrap_cnt), 32'(tab[i].wc));
        chk($sformatf("tab%0d_wrap_pulse", i), 32'(wrap_pulse), 32'(tab[i].wp));
        chk($sformatf("tab%0d_match_pulse", i), 32'(match_pulse), 32'(tab[i].mp));
        chk($sformatf("tab%0d_restart_seen", i), 32'(restart_seen), 32'(tab[i].rs));
        chk($sformatf("tab%0d_seq_err", i), 32'(seq_err), 32'(tab[i].se));
        chk($sformatf("tab%0d_irq", i), 32'(irq), 32'(tab[i].irq));
    endtask

    task automatic runRange(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            applyStimulus(tab[i].rst, tab[i].en, tab[i].ci, tab[i].mv,
                          tab[i].me, tab[i].ec, tab[i].ack);
            checkOutput();
            checkTable(i);
        end
    endtask

    initial begin
        int idxMatch, idxErr, idxRestart, idxFinal, idxEnd;
        int wpCount, bothCount;

        reset = 1'b0; en = 1'b0; count_in = 4'd0; match_val = 4'd0;
        match_en = 1'b0; err_clr = 1'b0; irq_ack = 1'b0;
        m_st = 0; m_prev = 4'd0; m_out = '0;

        //             rst en ci mv me ec ack | wc wp mp rs se irq
        tab.push_back(mk(0, 1, 5, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(0, 1, 5, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        idxMatch = tab.size();
        tab.push_back(mk(1, 1, 0, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 0, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 1, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 2, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 3, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 4, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 5, 5, 1, 0, 0,   0, 0, 1, 0, 0, 1));
        tab.push_back(mk(1, 1, 6, 5, 1, 0, 0,   0, 0, 0, 0, 0, 1));
        tab.push_back(mk(1, 1, 6, 5, 1, 0, 1,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 6, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 7, 7, 1, 0, 0,   0, 0, 1, 0, 0, 1));
        tab.push_back(mk(1, 1, 8, 8, 1, 0, 1,   0, 0, 1, 0, 0, 1));
        tab.push_back(mk(1, 1, 8, 8, 1, 0, 1,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 8, 8, 1, 0, 1,   0, 0, 0, 0, 0, 0));
        idxErr = tab.size();
        tab.push_back(mk(1, 0, 8, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 3, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 3, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 4, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 4, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 4, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 5, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 5, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 9, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1));
        tab.push_back(mk(1, 0, 10, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1));
        tab.push_back(mk(1, 0, 10, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1));
        tab.push_back(mk(1, 0, 10, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
        idxRestart = tab.size();
        tab.push_back(mk(1, 1, 14, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 14, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 15, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0));
        tab.push_back(mk(1, 1, 1, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0));
        idxFinal = tab.size();
        tab.push_back(mk(0, 1, 2, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 2, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0));
        idxEnd = tab.size();

        $display("[TB] reset");
        runRange(0, idxMatch);

        $display("[TB] two full ramps");
        wpCount = 0;
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < 16; v++) begin
                applyStimulus(1, 1, 4'(v), 4'd0, 0, 0, 0);
                checkOutput();
                if (wrap_pulse) wpCount++;
            end
        end
        applyStimulus(1, 1, 4'd0, 4'd0, 0, 0, 0);
        checkOutput();
        if (wrap_pulse) wpCount++;
        chk("ramp_wrap_pulses", 32'(wpCount), 32'd2);
        chk("ramp_wrap_cnt", 32'(wrap_cnt), 32'd2);
        chk("ramp_seq_err", 32'(seq_err), 32'd0);
        chk("ramp_restart_seen", 32'(restart_seen), 32'd0);
        applyStimulus(1, 0, 4'd0, 4'd0, 0, 0, 0);
        checkOutput();

        $display("[TB] match and irq handshake");
        runRange(idxMatch, idxErr);
        $display("[TB] holds then illegal jump");
        runRange(idxErr, idxRestart);
        $display("[TB] wrap then upstream restart");
        runRange(idxRestart, idxFinal);

        $display("[TB] five wraps with match on zero");
        wpCount   = 0;
        bothCount = 0;
        for (int v = 2; v < 16; v++) begin
            applyStimulus(1, 1, 4'(v), 4'd0, 1, 0, 0);
            checkOutput();
        end
        for (int r = 0; r < 5; r++) begin
            applyStimulus(1, 1, 4'd0, 4'd0, 1, 0, 0);
            checkOutput();
            if (wrap_pulse2) wpCount++;
            if (wrap_pulse && match_pulse) bothCount++;
            if (r < 4) begin
                for (int v = 1; v < 16; v++) begin
                    applyStimulus(1, 1, 4'(v), 4'd0, 1, 0, 0);
                    checkOutput();
                end
            end
        end
        chk("sat_wrap_pulses", 32'(wpCount), 32'd5);
        chk("sat_wrap_and_match", 32'(bothCount), 32'd5);
        chk("sat_wrap_cnt_w8", 32'(wrap_cnt), 32'd6);
        chk("sat_wrap_cnt_w2", 32'(wrap_cnt2), 32'd3);
        chk("sat_irq", 32'(irq), 32'd1);

        $display("[TB] reset pulse between edges");
        @(negedge clk);
        reset = 1'b0;
        #2;
        compareTo("glitch_", m_out);
        reset = 1'b1;
        applyStimulus(1, 1, 4'd1, 4'd0, 1, 0, 0);
        checkOutput();

        $display("[TB] reset mid-run");
        runRange(idxFinal, idxEnd);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
